// File: rtl/mux4_rr_arbiter_if.sv
// Handshake bundle between the four requesters and the round-robin arbiter.
// The arbiter side uses the slave modport.
interface mux4_rr_arbiter_if;
    logic [3:0] Req;
    logic [3:0] Done;
    logic [1:0] Sel;
    logic [3:0] Gnt;
    logic       Busy;
    logic       Timeout;

    modport master (
        output Req,
        output Done,
        input  Sel,
        input  Gnt,
        input  Busy,
        input  Timeout
    );

    modport slave (
        input  Req,
        input  Done,
        output Sel,
        output Gnt,
        output Busy,
        output Timeout
    );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving the select lines of a 4:1 mux.
// One grant at a time, with a bounded hold so a stuck requester cannot starve
// the others. All outputs are registered, so Sel and Gnt move together.
module mux4_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 8
) (
    input logic               clk,
    input logic               rst_n,
    mux4_rr_arbiter_if.slave  bus
);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e     state_q;
    logic [1:0] last_q;
    logic [7:0] cnt_q;
    logic [3:0] gnt_q;
    logic [1:0] sel_q;
    logic       busy_q;
    logic       timeout_q;

    logic       found;
    logic [1:0] win;
    logic [1:0] idx;
    logic       done_g;
    logic       req_g;
    logic       limit;
    logic       release_g;

    // Search last+1 .. last+4 so the previous winner sits at lowest priority.
    always_comb begin
        found = 1'b0;
        win   = last_q;
        idx   = last_q;
        for (int i = 1; i <= 4; i++) begin
            idx = last_q + 2'(i);
            if (!found && bus.Req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    // While granting, last_q is the granted index.
    always_comb begin
        done_g    = bus.Done[last_q];
        req_g     = bus.Req[last_q];
        limit     = (cnt_q == 8'(MAX_HOLD - 1));
        release_g = done_g || !req_g || limit;
    end

    // Arbitration FSM with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            last_q    <= 2'b11;
            cnt_q     <= 8'd0;
            gnt_q     <= 4'b0000;
            sel_q     <= 2'b00;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (found) begin
                        state_q <= StGrant;
                        gnt_q   <= 4'b0001 << win;
                        sel_q   <= win;
                        last_q  <= win;
                        cnt_q   <= 8'd0;
                        busy_q  <= 1'b1;
                    end else begin
                        gnt_q  <= 4'b0000;
                        busy_q <= 1'b0;
                    end
                end
                StGrant: begin
                    if (release_g) begin
                        // A normal release takes precedence over a forced one.
                        timeout_q <= limit && !done_g && req_g;
                        if (found) begin
                            gnt_q  <= 4'b0001 << win;
                            sel_q  <= win;
                            last_q <= win;
                            cnt_q  <= 8'd0;
                            busy_q <= 1'b1;
                        end else begin
                            state_q <= StIdle;
                            gnt_q   <= 4'b0000;
                            cnt_q   <= 8'd0;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.Gnt     = gnt_q;
    assign bus.Sel     = sel_q;
    assign bus.Busy    = busy_q;
    assign bus.Timeout = timeout_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Scoreboard bench for mux4_rr_arbiter with MAX_HOLD = 8.
// Stimulus pushes the expected post-edge outputs; a monitor pops and checks.
module tb_mux4_rr_arbiter;

    typedef struct packed {
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       busy;
        logic       to;
    } exp_t;

    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    exp_t  exp_q[$];
    string name_q[$];

    mux4_rr_arbiter_if bus ();

    mux4_rr_arbiter #(
        .MAX_HOLD(8)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input exp_t e);
        exp_t act;
        act = '{gnt: bus.Gnt, sel: bus.Sel, busy: bus.Busy, to: bus.Timeout};
        total++;
        if (act !== e) begin
            bad++;
            $display("FAIL %s: got gnt=%b sel=%b busy=%b to=%b, want gnt=%b sel=%b busy=%b to=%b",
                     nm, act.gnt, act.sel, act.busy, act.to, e.gnt, e.sel, e.busy, e.to);
        end
    endtask

    // Called at a negedge: drive inputs, queue the expected result, advance.
    task automatic step(input logic [3:0] req, input logic [3:0] done,
                        input logic [3:0] g, input logic [1:0] s, input logic b,
                        input logic t, input string nm);
        bus.Req  = req;
        bus.Done = done;
        exp_q.push_back('{gnt: g, sel: s, busy: b, to: t});
        name_q.push_back(nm);
        @(negedge clk);
    endtask

    // Monitor: compare one queued expectation just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            check(name_q.pop_front(), exp_q.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        bus.Req  = 4'b0000;
        bus.Done = 4'b0000;
        #1;
        check("reset", '{gnt: 4'b0000, sel: 2'b00, busy: 1'b0, to: 1'b0});
        @(negedge clk);
        rst_n = 1'b1;

        // Rotation with all requesting, granted Done pulsed every cycle.
        step(4'b1111, 4'b0000, 4'b0001, 2'd0, 1, 0, "rr_first");
        step(4'b1111, 4'b0001, 4'b0010, 2'd1, 1, 0, "rr_1");
        step(4'b1111, 4'b0010, 4'b0100, 2'd2, 1, 0, "rr_2");
        step(4'b1111, 4'b0100, 4'b1000, 2'd3, 1, 0, "rr_3");
        step(4'b1111, 4'b1000, 4'b0001, 2'd0, 1, 0, "rr_wrap");

        // Single request on C, then release with Done[2].
        step(4'b0100, 4'b0001, 4'b0100, 2'd2, 1, 0, "single_grant");
        step(4'b0000, 4'b0100, 4'b0000, 2'd2, 0, 0, "single_release");
        step(4'b0000, 4'b0000, 4'b0000, 2'd2, 0, 0, "idle_hold_sel");

        // Forced release: A held for exactly 8 cycles, then B with Timeout.
        step(4'b0011, 4'b0000, 4'b0001, 2'd0, 1, 0, "hold_c1");
        for (int i = 2; i <= 8; i++) begin
            step(4'b0011, 4'b0000, 4'b0001, 2'd0, 1, 0, $sformatf("hold_c%0d", i));
        end
        step(4'b0011, 4'b0000, 4'b0010, 2'd1, 1, 1, "timeout_handoff");
        step(4'b0011, 4'b0000, 4'b0010, 2'd1, 1, 0, "timeout_one_cycle");

        // Collision: Done[1] on the cycle the counter reaches 7.
        for (int i = 2; i <= 7; i++) begin
            step(4'b0011, 4'b0000, 4'b0010, 2'd1, 1, 0, $sformatf("coll_c%0d", i));
        end
        step(4'b0011, 4'b0010, 4'b0001, 2'd0, 1, 0, "collision_no_timeout");

        // Stray Done and request drop.
        step(4'b0010, 4'b0001, 4'b0010, 2'd1, 1, 0, "grant_b");
        step(4'b0010, 4'b1000, 4'b0010, 2'd1, 1, 0, "stray_done");
        step(4'b0000, 4'b0000, 4'b0000, 2'd1, 0, 0, "req_drop");

        // Async reset in the middle of a grant.
        step(4'b0100, 4'b0000, 4'b0100, 2'd2, 1, 0, "grant_c");
        rst_n = 1'b0;
        #1;
        check("async_reset", '{gnt: 4'b0000, sel: 2'b00, busy: 1'b0, to: 1'b0});
        bus.Req = 4'b1111;
        @(negedge clk);
        rst_n = 1'b1;
        step(4'b1111, 4'b0000, 4'b0001, 2'd0, 1, 0, "post_reset_first");
        step(4'b1111, 4'b0001, 4'b0010, 2'd1, 1, 0, "post_reset_next");

        @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux4_rr_arbiter.md
# mux4_rr_arbiter

Round-robin arbiter and select controller for the 4-input, 1-bit `mux_4x1` datapath. Four requesters compete for the shared mux output. The block grants one requester at a time and drives the mux `Sel` lines to route that requester's input to `Y`. It also enforces a bounded hold time, so a stuck requester cannot starve the others.

## Interface
- `MAX_HOLD`, default 8: maximum cycles one grant may be held before forced release. Legal range is 2..255.
- `clk` in 1: single clock, rising-edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `Req` in 4: request per requester. Bit 0 maps to mux input A, bit 1 to B, bit 2 to C, bit 3 to D. Level-sensitive.
- `Done` in 4: per-requester release strobe. Honoured only on the currently granted bit.
- `Sel` out 2: mux select, wired straight to `mux_4x1.Sel`.
- `Gnt` out 4: one-hot grant. All zero when idle.
- `Busy` out 1: high while any grant is active.
- `Timeout` out 1: one-cycle pulse when a grant is forcibly revoked.

## Operation
- Reset values: `Gnt`=4'b0000, `Sel`=2'b00, `Busy`=0, `Timeout`=0, state=IDLE, pointer `last`=2'b11, hold counter=0.
- Because `last` resets to 2'b11, requester 0 has top priority after reset.
- State machine has two states, IDLE and GRANT.
- IDLE behaviour:
  - If `Req`≠0, pick the first set bit searching `last+1, last+2, …` modulo 4.
  - Set `Gnt` one-hot for the winner, `Sel`=winner index, `last`=winner, counter=0, and go to GRANT.
  - Otherwise stay in IDLE with `Gnt`=0 and `Sel` holding its previous value.
- GRANT behaviour: the counter increments every cycle. A release occurs at the edge where any of these holds:
  - `Done[g]`=1, where g is the granted index.
  - `Req[g]`=0.
  - counter==`MAX_HOLD`-1.
- On release:
  - Re-arbitrate in the same edge, searching from g+1.
  - If any `Req` bit other than g is set, grant it directly. This is a back-to-back handoff with no idle cycle.
  - If only g is requesting, g is regranted (lowest priority).
  - If nothing is requesting, go to IDLE.
- `Timeout` fires only when the counter limit caused the release and neither `Done[g]` nor a `Req[g]` drop occurred that cycle. A normal release wins over timeout when both happen in the same cycle.
- `Done` bits for non-granted requesters are ignored. A simultaneous multi-bit `Done` acts only on bit g.
- `Sel` and `Gnt` always change on the same edge. `Sel` never glitches between grants, because both are registered.
- `Busy` equals OR of `Gnt`, registered.
- Reset asserted mid-grant clears `Gnt`, `Busy` and `Timeout` immediately (asynchronously) and restores all reset values. No release pulse is emitted.

## Timing
- Grant latency: `Req` sampled at edge N, so `Gnt`/`Sel` are valid after edge N. That is one cycle from request to grant.
- Release latency: `Done[g]` sampled at edge N. `Gnt[g]` drops after edge N, and the next grantee (if any) is visible in the same cycle.
- Maximum hold: a grant is visible for at most `MAX_HOLD` cycles.
- `Timeout` is high for exactly the one cycle following the forced-release edge.
- Worst-case wait for any continuously requesting input: 3×`MAX_HOLD`+1 cycles.
- Data path timing: the mux is combinational, so `Y` reflects the granted input in the same cycle `Sel` updates.

## Test plan
- **Single request:** reset, then `Req`=4'b0100.
  - Expect `Gnt`=4'b0100, `Sel`=2'b10, `Busy`=1 after one edge.
  - Pulse `Done[2]`: expect `Gnt`=0 and `Busy`=0 on the next cycle, with `Sel` still 2'b10.
- **Round-robin rotation:** hold `Req`=4'b1111 and pulse the granted `Done` each cycle.
  - Expect grant order 0,1,2,3,0 with `Sel` 00,01,10,11,00.
  - Expect no idle cycle between grants.
- **Forced release:** `MAX_HOLD`=8, `Req`=4'b0011, `Done`=0.
  - Expect `Gnt`=4'b0001 for exactly 8 cycles, then `Gnt`=4'b0010.
  - Expect a `Timeout` pulse of one cycle at the handoff.
- **Release collision:** `Done[g]` asserted on the same cycle the counter reaches 7. Expect release with `Timeout`=0.
- **Stray done / request drop:**
  - `Done`=4'b1000 while g=1 has no effect.
  - Dropping `Req[1]` releases the grant at the next edge without `Timeout`.
- **Async reset mid-grant:** deassert `rst_n` between clock edges while `Gnt`=4'b0100.
  - Expect `Gnt`=0, `Sel`=00, `Busy`=0 immediately.
  - After release with `Req`=4'b1111, the first grant goes to requester 0.
